multicycle_control_unit: RTL and testbench
==========================================

// Module: multicycle_control_unit
// PURPOSE
//  Main control FSM of the multi-cycle RV64 core. Sequences the shared ALU, the unified
//  instruction/data memory, the IR, the register file and the PC through FETCH/DECODE/EXECUTE/
//  MEM/WRITEBACK steps. Drives the 2-bit alu_op consumed by the ALU (00 add, 01 sub,
//  10 funct decode). Supports R-type add/sub/and/or, ld, sd and beq.
// PARAMETERS
//  INSTRUCTION_LEN  32  width of instruction input; opcode = instruction[6:0]
// PORTS
//  clk            in   1   single clock; all state changes on posedge
//  rst            in   1   asynchronous, active-high reset
//  run            in   1   leave IDLE and start fetching when 1
//  instruction    in   INSTRUCTION_LEN  IR contents; only [6:0] is used
//  mem_ready      in   1   memory completed the current read/write this cycle
//  pc_write       out  1   unconditional PC load
//  pc_write_cond  out  1   PC load qualified by ALU zero (beq)
//  pc_source      out  1   0: ALU result, 1: ALUOut register (branch target)
//  i_or_d         out  1   memory address select, 0: PC, 1: ALUOut
//  mem_read       out  1   memory read request
//  mem_write      out  1   memory write request
//  ir_write       out  1   load IR from memory data
//  mem_to_reg     out  1   regfile write data, 0: ALUOut, 1: MDR
//  reg_write      out  1   regfile write enable
//  alu_src_a      out  1   0: PC, 1: register A
//  alu_src_b      out  2   00: reg B, 01: const 4, 10: imm, 11: imm<<1
//  alu_op         out  2   to ALU: 00 add, 01 sub, 10 decode funct7/funct3
//  instr_done     out  1   one-cycle pulse on the last cycle of each retired instruction
//  illegal_instr  out  1   sticky; unsupported opcode decoded
// BEHAVIOUR
//  - Moore FSM: state register async-reset to IDLE. Outputs are a pure function of state,
//    plus mem_ready where noted. All outputs are 0 in IDLE and during reset.
//  - IDLE: run=1 -> FETCH, else stay.
//  - FETCH: mem_read=1, i_or_d=0, src_a=0, src_b=01, alu_op=00.
//    While mem_ready=0: stay; ir_write=0, pc_write=0.
//    On mem_ready=1: ir_write=1, pc_write=1, pc_source=0 -> DECODE.
//  - DECODE: src_a=0, src_b=11, alu_op=00 (branch target into ALUOut). By opcode:
//    0110011 -> EXEC_R; 0000011 or 0100011 -> MEM_ADDR; 1100011 -> BRANCH;
//    any other opcode -> ILLEGAL.
//  - EXEC_R: src_a=1, src_b=00, alu_op=10 -> WB_R.
//  - WB_R: reg_write=1, mem_to_reg=0, instr_done=1 -> FETCH.
//  - MEM_ADDR: src_a=1, src_b=10, alu_op=00. ld -> MEM_RD, sd -> MEM_WR.
//  - MEM_RD: mem_read=1, i_or_d=1. Stay until mem_ready=1, then -> WB_MEM.
//  - WB_MEM: reg_write=1, mem_to_reg=1, instr_done=1 -> FETCH.
//  - MEM_WR: mem_write=1, i_or_d=1. Stay until mem_ready=1; on that cycle
//    instr_done=1 -> FETCH.
//  - BRANCH: src_a=1, src_b=00, alu_op=01, pc_write_cond=1, pc_source=1, instr_done=1 -> FETCH.
//  - ILLEGAL: illegal_instr=1, all other outputs 0. Terminal; only rst exits.
//  - Latency (cycles incl. FETCH, mem_ready tied 1): R=4, ld=5, sd=4, beq=3.
//  - run is only sampled in IDLE; deasserting it mid-instruction has no effect.
//  - mem_read and mem_write are never both 1. reg_write and pc_write are never both 1.
//  - rst mid-instruction: the FSM goes to IDLE immediately (asynchronous). Outputs drop to 0
//    in the same cycle, and any pending memory request is abandoned.
//  - mem_ready asserted outside FETCH/MEM_RD/MEM_WR is ignored.
// STRUCTURE
//  - Shared include riscv_ctrl_defs.vh holds:
//    - opcode constants (OP_RTYPE, OP_LOAD, OP_STORE, OP_BRANCH);
//    - state encodings (4-bit);
//    - ALU_OP_ADD/SUB/FUNCT;
//    - SRC_B_REG/FOUR/IMM/IMM_SH.
//  - One sub-module: ctrl_opcode_class, combinational. Maps opcode[6:0] to one-hot class
//    {rtype, load, store, branch, illegal}; used by the DECODE and MEM_ADDR next-state logic.
// TESTING
//  1. Assert rst mid-stream -> all outputs 0 in the same cycle. After release with run=0 the FSM
//     stays in IDLE; run=1 gives FETCH on the next edge.
//  2. R-type 0x002081B3 (add), mem_ready=1 -> states FETCH,DECODE,EXEC_R,WB_R.
//     alu_op=10 in EXEC_R; reg_write=1 and instr_done=1 only in WB_R.
//  3. ld 0x0000B183 with mem_ready held low 3 cycles in MEM_RD -> MEM_RD held 4 cycles
//     (mem_read=1, i_or_d=1 throughout). Then WB_MEM with mem_to_reg=1.
//  4. sd 0x0030B023 -> mem_write=1 only in MEM_WR; reg_write stays 0.
//     instr_done pulses exactly once, on the mem_ready cycle.
//  5. beq 0x00208463 -> BRANCH has alu_op=01, pc_write_cond=1, pc_source=1; 3 cycles total.
//  6. Opcode 0x7F -> ILLEGAL after DECODE; illegal_instr stays 1 for 10+ cycles with
//     mem_read=0, until rst.

Source files
------------

// File: rtl/multicycle_control_unit_pkg.sv
// Shared definitions for the multi-cycle RV64 control unit: opcode
// constants, the 4-bit FSM state encoding, ALU operation codes, ALU
// B-operand selects and the one-hot opcode class.
package multicycle_control_unit_pkg;

  // Supported major opcodes (instruction[6:0])
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // ALU operation requested from the shared ALU
  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  // ALU B-operand select
  localparam logic [1:0] SRC_B_REG    = 2'b00;
  localparam logic [1:0] SRC_B_FOUR   = 2'b01;
  localparam logic [1:0] SRC_B_IMM    = 2'b10;
  localparam logic [1:0] SRC_B_IMM_SH = 2'b11;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_EXEC_R   = 4'd3,
    S_WB_R     = 4'd4,
    S_MEM_ADDR = 4'd5,
    S_MEM_RD   = 4'd6,
    S_WB_MEM   = 4'd7,
    S_MEM_WR   = 4'd8,
    S_BRANCH   = 4'd9,
    S_ILLEGAL  = 4'd10
  } state_e;

  // One-hot instruction class; exactly one field is set for any opcode
  typedef struct packed {
    logic rtype;
    logic load;
    logic store;
    logic branch;
    logic illegal;
  } opclass_t;

endpackage

// File: rtl/multicycle_control_unit_opcode_class.sv
// ctrl_opcode_class: combinational opcode classifier.
// Ports:
//   opcode_i  in  7  instruction[6:0]
//   class_o   out 5  one-hot {rtype, load, store, branch, illegal}
module ctrl_opcode_class
  import multicycle_control_unit_pkg::*;
(
  input  logic [6:0] opcode_i,
  output opclass_t   class_o
);

  always_comb begin
    class_o = '0;
    unique case (opcode_i)
      OP_RTYPE:  class_o.rtype  = 1'b1;
      OP_LOAD:   class_o.load   = 1'b1;
      OP_STORE:  class_o.store  = 1'b1;
      OP_BRANCH: class_o.branch = 1'b1;
      default:   class_o.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: main control FSM of the multi-cycle RV64 core.
// Sequences FETCH/DECODE/EXECUTE/MEM/WRITEBACK for add/sub/and/or, ld, sd
// and beq; unknown opcodes park the FSM in a terminal ILLEGAL state.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   run             start fetching from IDLE (sampled only in IDLE)
//   instruction     IR contents, only [6:0] used
//   mem_ready       memory finished current access this cycle
//   pc_write, pc_write_cond, pc_source       PC update controls
//   i_or_d, mem_read, mem_write              memory controls
//   ir_write, mem_to_reg, reg_write          IR / register file controls
//   alu_src_a, alu_src_b, alu_op             ALU operand and op selects
//   instr_done      pulse on last cycle of each retired instruction
//   illegal_instr   high while parked in ILLEGAL (sticky until rst)
module multicycle_control_unit
  import multicycle_control_unit_pkg::*;
#(
  parameter int INSTRUCTION_LEN = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       run,
  input  logic [INSTRUCTION_LEN-1:0] instruction,
  input  logic                       mem_ready,
  output logic                       pc_write,
  output logic                       pc_write_cond,
  output logic                       pc_source,
  output logic                       i_or_d,
  output logic                       mem_read,
  output logic                       mem_write,
  output logic                       ir_write,
  output logic                       mem_to_reg,
  output logic                       reg_write,
  output logic                       alu_src_a,
  output logic [1:0]                 alu_src_b,
  output logic [1:0]                 alu_op,
  output logic                       instr_done,
  output logic                       illegal_instr
);

  state_e   state_q;
  opclass_t opclass;

  // Upper instruction bits are decoded by the datapath, not here
  logic unused_instr_bits;
  assign unused_instr_bits = ^instruction[INSTRUCTION_LEN-1:7];

  ctrl_opcode_class u_opclass (
    .opcode_i (instruction[6:0]),
    .class_o  (opclass)
  );

  // State register with next-state logic inline
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE:     if (run) state_q <= S_FETCH;
        S_FETCH:    if (mem_ready) state_q <= S_DECODE;
        S_DECODE: begin
          if (opclass.rtype)                      state_q <= S_EXEC_R;
          else if (opclass.load || opclass.store) state_q <= S_MEM_ADDR;
          else if (opclass.branch)                state_q <= S_BRANCH;
          else                                    state_q <= S_ILLEGAL;
        end
        S_EXEC_R:   state_q <= S_WB_R;
        S_WB_R:     state_q <= S_FETCH;
        S_MEM_ADDR: state_q <= opclass.load ? S_MEM_RD : S_MEM_WR;
        S_MEM_RD:   if (mem_ready) state_q <= S_WB_MEM;
        S_WB_MEM:   state_q <= S_FETCH;
        S_MEM_WR:   if (mem_ready) state_q <= S_FETCH;
        S_BRANCH:   state_q <= S_FETCH;
        S_ILLEGAL:  state_q <= S_ILLEGAL;
        default:    state_q <= S_IDLE;
      endcase
    end
  end

  // Outputs decode from the registered state. The few that must react to
  // mem_ready in the same cycle (IR/PC load, store retire) cannot be
  // registered, so the whole decode stays combinational; since the state
  // resets asynchronously to IDLE, outputs drop to 0 as soon as rst rises.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRC_B_REG;
    alu_op        = ALU_OP_ADD;
    instr_done    = 1'b0;
    illegal_instr = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRC_B_FOUR;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: begin
        // Speculative branch target into ALUOut
        alu_src_b = SRC_B_IMM_SH;
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_OP_FUNCT;
      end
      S_WB_R: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRC_B_IMM;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
      end
      S_MEM_WR: begin
        mem_write  = 1'b1;
        i_or_d     = 1'b1;
        instr_done = mem_ready;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALU_OP_SUB;
        pc_write_cond = 1'b1;
        pc_source     = 1'b1;
        instr_done    = 1'b1;
      end
      S_ILLEGAL: illegal_instr = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit. States are observed through
// the full output vector; each expected vector is a hand-computed constant.
module tb_multicycle_control_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic [31:0] instruction;
  logic        mem_ready;
  logic        pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write;
  logic        ir_write, mem_to_reg, reg_write, alu_src_a, instr_done, illegal_instr;
  logic [1:0]  alu_src_b, alu_op;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multicycle_control_unit #(.INSTRUCTION_LEN(32)) dut (
    .clk(clk), .rst(rst), .run(run), .instruction(instruction), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
    .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .instr_done(instr_done),
    .illegal_instr(illegal_instr)
  );

  // {pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write, ir_write,
  //  mem_to_reg, reg_write, alu_src_a, alu_src_b[1:0], alu_op[1:0], instr_done, illegal}
  logic [15:0] outv;
  assign outv = {pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
                 ir_write, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
                 instr_done, illegal_instr};

  localparam logic [15:0] V_IDLE    = 16'h0000;
  localparam logic [15:0] V_FETCH   = 16'h8A10; // mem_ready=1
  localparam logic [15:0] V_FETCH_W = 16'h0810; // mem_ready=0
  localparam logic [15:0] V_DECODE  = 16'h0030;
  localparam logic [15:0] V_EXEC_R  = 16'h0048;
  localparam logic [15:0] V_WB_R    = 16'h0082;
  localparam logic [15:0] V_MADDR   = 16'h0060;
  localparam logic [15:0] V_MEM_RD  = 16'h1800;
  localparam logic [15:0] V_WB_MEM  = 16'h0182;
  localparam logic [15:0] V_MEM_WR  = 16'h1400; // mem_ready=0
  localparam logic [15:0] V_MEM_WRD = 16'h1402; // mem_ready=1
  localparam logic [15:0] V_BRANCH  = 16'h6046;
  localparam logic [15:0] V_ILLEGAL = 16'h0001;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; instruction = 32'h0; mem_ready = 1'b0;
    #1;
    chk("reset_outputs", {16'h0, outv}, {16'h0, V_IDLE});
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("idle_run0", {16'h0, outv}, {16'h0, V_IDLE});
    tick();
    chk("idle_run0_hold", {16'h0, outv}, {16'h0, V_IDLE});

    // R-type add, mem_ready tied high: 4 cycles
    instruction = 32'h002081B3; mem_ready = 1'b1; run = 1'b1;
    tick(); chk("r_fetch", {16'h0, outv}, {16'h0, V_FETCH});
    run = 1'b0; // ignored outside IDLE
    tick(); chk("r_decode", {16'h0, outv}, {16'h0, V_DECODE});
    tick(); chk("r_exec", {16'h0, outv}, {16'h0, V_EXEC_R});
    tick(); chk("r_wb", {16'h0, outv}, {16'h0, V_WB_R});

    // ld with FETCH stall and 3 wait cycles in MEM_RD
    tick();
    mem_ready = 1'b0;
    #1 chk("ld_fetch_wait", {16'h0, outv}, {16'h0, V_FETCH_W});
    tick(); chk("ld_fetch_wait2", {16'h0, outv}, {16'h0, V_FETCH_W});
    instruction = 32'h0000B183; mem_ready = 1'b1;
    #1 chk("ld_fetch", {16'h0, outv}, {16'h0, V_FETCH});
    tick(); chk("ld_decode", {16'h0, outv}, {16'h0, V_DECODE});
    tick(); chk("ld_maddr", {16'h0, outv}, {16'h0, V_MADDR});
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(); chk("ld_mem_rd_wait", {16'h0, outv}, {16'h0, V_MEM_RD});
    end
    mem_ready = 1'b1;
    #1 chk("ld_mem_rd_done", {16'h0, outv}, {16'h0, V_MEM_RD});
    tick(); chk("ld_wb_mem", {16'h0, outv}, {16'h0, V_WB_MEM});

    // sd with one wait cycle in MEM_WR
    tick(); chk("sd_fetch", {16'h0, outv}, {16'h0, V_FETCH});
    instruction = 32'h0030B023;
    tick(); chk("sd_decode", {16'h0, outv}, {16'h0, V_DECODE});
    tick(); chk("sd_maddr", {16'h0, outv}, {16'h0, V_MADDR});
    mem_ready = 1'b0;
    tick(); chk("sd_mem_wr_wait", {16'h0, outv}, {16'h0, V_MEM_WR});
    mem_ready = 1'b1;
    #1 chk("sd_mem_wr_done", {16'h0, outv}, {16'h0, V_MEM_WRD});

    // beq: FETCH, DECODE, BRANCH
    tick(); chk("beq_fetch", {16'h0, outv}, {16'h0, V_FETCH});
    instruction = 32'h00208463;
    tick(); chk("beq_decode", {16'h0, outv}, {16'h0, V_DECODE});
    tick(); chk("beq_branch", {16'h0, outv}, {16'h0, V_BRANCH});
    tick(); chk("beq_next_fetch", {16'h0, outv}, {16'h0, V_FETCH});

    // Reset mid-stream with a fetch pending
    mem_ready = 1'b0;
    #1 chk("pre_rst_fetch_wait", {16'h0, outv}, {16'h0, V_FETCH_W});
    #2 rst = 1'b1;
    #1 chk("rst_async_outputs", {16'h0, outv}, {16'h0, V_IDLE});
    tick();
    rst = 1'b0; run = 1'b0; mem_ready = 1'b1;
    tick(); tick();
    chk("post_rst_idle", {16'h0, outv}, {16'h0, V_IDLE});
    run = 1'b1;
    tick(); chk("post_rst_fetch", {16'h0, outv}, {16'h0, V_FETCH});

    // Unsupported opcode parks in ILLEGAL
    instruction = 32'h0000007F;
    tick(); chk("ill_decode", {16'h0, outv}, {16'h0, V_DECODE});
    tick(); chk("ill_enter", {16'h0, outv}, {16'h0, V_ILLEGAL});
    for (int i = 0; i < 12; i++) begin
      tick(); chk("ill_sticky", {16'h0, outv}, {16'h0, V_ILLEGAL});
    end
    rst = 1'b1;
    #1 chk("ill_rst", {16'h0, outv}, {16'h0, V_IDLE});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Structural exclusions checked every cycle
  always @(negedge clk) begin
    if (mem_read && mem_write) begin
      errors++;
      $display("FAIL excl_mem: mem_read=%b mem_write=%b required not both 1", mem_read, mem_write);
    end
    if (reg_write && pc_write) begin
      errors++;
      $display("FAIL excl_wr: reg_write=%b pc_write=%b required not both 1", reg_write, pc_write);
    end
  end

endmodule
